// File: rtl/mem_line_port.sv
// Line-transfer engine between the cache and a word-write / line-read memory:
// optional 4-word victim writeback, then a single-cycle line fill and response.
module mem_line_port #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_fill_addr,
  input  logic                req_wb_en,
  input  logic [ADDR_W-1:0]   req_wb_addr,
  input  logic [4*DATA_W-1:0] req_wb_data,
  output logic                rsp_valid,
  output logic [4*DATA_W-1:0] rsp_data,
  output logic                mem_cs,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [4*DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               k, k_nxt;
  logic [ADDR_W-3:0]        fill_line, wb_line_addr;
  logic [3:0][DATA_W-1:0]   wb_words;
  logic [ADDR_W-1:0]        last_waddr;
  logic [DATA_W-1:0]        last_wdata;
  logic                     accept;

  // Line offsets are forced to zero, so only the line-number bits are kept.
  logic unused;
  assign unused = &{1'b0, req_fill_addr[1:0], req_wb_addr[1:0]};

  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: if (accept) begin
        state_nxt = req_wb_en ? WB : FILL;
        k_nxt     = 2'd0;
      end
      WB: begin
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = FILL;
      end
      FILL:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Base address has zero offset bits, so base+k is just {line, k}: no wrap.
  // Word 0 sits in the top slice, hence packed index ~k.
  always_comb begin
    req_ready = reset && (state == IDLE);
    rsp_valid = (state == RESP);
    mem_cs    = (state == WB) || (state == FILL);
    mem_rw    = (state == WB);
    mem_raddr = {fill_line, 2'b00};
    mem_waddr = last_waddr;
    mem_wdata = last_wdata;
    if (state == WB) begin
      mem_waddr = {wb_line_addr, k};
      mem_wdata = wb_words[~k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      k            <= 2'd0;
      fill_line    <= '0;
      wb_line_addr <= '0;
      wb_words     <= '0;
      last_waddr   <= '0;
      last_wdata   <= '0;
      rsp_data     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (accept) begin
        fill_line    <= req_fill_addr[ADDR_W-1:2];
        wb_line_addr <= req_wb_addr[ADDR_W-1:2];
        wb_words     <= req_wb_data;
      end
      if (state == WB) begin
        last_waddr <= mem_waddr;
        last_wdata <= mem_wdata;
      end
      if (state == FILL) rsp_data <= mem_rdata;
    end
  end

endmodule
